udp_tx_ctrl: RTL

Transmit sequencer between the AXI4-Lite UDP register file and the downstream IP/MAC framer. Waits for the destination IP, port pair and payload length registers to be loaded, acknowledges them through the `*_got` handshake, and emits an 8-byte UDP header. It then streams payload words, one per host write to the payload register, as a 32-bit valid/ready stream with byte keep and last. The block owns all ack signalling back to the register file, so host software paces the payload one word per write.

---
 rtl/udp_tx_ctrl.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/udp_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : udp_tx_ctrl
// Description : UDP transmit sequencer. Collects the destination IP, port pair
//               and payload length from the register file through a level
//               ack handshake, emits the 8-byte UDP header as two 32-bit beats
//               and then forwards one payload word per host register write.
//               A frame whose length exceeds MAX_LEN is rejected. An optional
//               PAY_WAIT timeout closes the frame with an empty last beat.
// Ports       : clk, rst                       clock, sync active-high reset
//               in_reg1..in_reg4               dst IP, ports, payload, length
//               slv_reg1..4_loaded             register-loaded flags
//               dip_got, src_dest_prt_got,
//               payload_length_got, payload_got  acks to the register file
//               ip_dst                         latched destination IP
//               tx_data/keep/valid/last/ready  32-bit output stream
//               busy, tx_done, tx_err          status
// Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_ctrl #(
   parameter int unsigned MAX_LEN     = 1472,
   parameter int unsigned TIMEOUT_CYC = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_reg1,
   input  logic [31:0] in_reg2,
   input  logic [31:0] in_reg3,
   input  logic [31:0] in_reg4,
   input  logic        slv_reg1_loaded,
   input  logic        slv_reg2_loaded,
   input  logic        slv_reg3_loaded,
   input  logic        slv_reg4_loaded,
   output logic        dip_got,
   output logic        src_dest_prt_got,
   output logic        payload_length_got,
   output logic        payload_got,
   output logic [31:0] ip_dst,
   output logic [31:0] tx_data,
   output logic [3:0]  tx_keep,
   output logic        tx_valid,
   output logic        tx_last,
   input  logic        tx_ready,
   output logic        busy,
   output logic        tx_done,
   output logic        tx_err
);

   localparam logic [15:0] c_MAX_LEN  = 16'(MAX_LEN);
   localparam logic [23:0] c_TO_LIMIT = 24'(TIMEOUT_CYC);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_HDR_ACK  = 4'd1,
      S_HDR0     = 4'd2,
      S_HDR1     = 4'd3,
      S_PAY_WAIT = 4'd4,
      S_PAY_SEND = 4'd5,
      S_TO_SEND  = 4'd6,
      S_DONE     = 4'd7,
      S_ERR      = 4'd8
   } state_t;

   state_t      r_state,    w_state_nxt;
   logic [31:0] r_ip_dst,   w_ip_dst_nxt;
   logic [31:0] r_ports,    w_ports_nxt;
   logic [15:0] r_len,      w_len_nxt;
   logic [13:0] r_wcnt,     w_wcnt_nxt;
   logic [23:0] r_to_cnt,   w_to_cnt_nxt;
   logic        r_hdr_ack,  w_hdr_ack_nxt;
   logic        r_pay_got,  w_pay_got_nxt;
   logic [31:0] r_tx_data,  w_data_nxt;
   logic [3:0]  r_tx_keep,  w_keep_nxt;
   logic        r_tx_valid, w_valid_nxt;
   logic        r_tx_last,  w_last_nxt;
   logic        r_busy,     w_busy_nxt;
   logic        r_tx_done,  w_done_nxt;
   logic        r_tx_err,   w_err_nxt;

   logic        w_accept;
   logic        w_hdr_loaded;
   logic        w_hdr_clear;
   logic [16:0] w_len_p3;
   logic [13:0] w_nwords;
   logic        w_last_word;
   logic [3:0]  w_last_keep;
   logic        w_to_hit;
   logic        w_unused;

   assign w_accept     = r_tx_valid & tx_ready;
   assign w_hdr_loaded = slv_reg1_loaded & slv_reg2_loaded & slv_reg4_loaded;
   assign w_hdr_clear  = ~(slv_reg1_loaded | slv_reg2_loaded | slv_reg4_loaded);
   // Lengths above MAX_LEN never reach the payload states, so 14 bits of
   // word count are always enough.
   assign w_len_p3     = {1'b0, r_len} + 17'd3;
   assign w_nwords     = w_len_p3[15:2];
   assign w_last_word  = (r_wcnt == w_nwords - 14'd1);
   // Counter value k means the (k+1)-th cycle spent in PAY_WAIT.
   assign w_to_hit     = (c_TO_LIMIT != 24'd0) && (r_to_cnt == c_TO_LIMIT - 24'd1);
   assign w_unused     = ^{in_reg4[31:16], w_len_p3[16], w_len_p3[1:0]};

   always_comb begin
      w_last_keep = 4'b1111;
      case (r_len[1:0])
         2'b01:   w_last_keep = 4'b1000;
         2'b10:   w_last_keep = 4'b1100;
         2'b11:   w_last_keep = 4'b1110;
         default: w_last_keep = 4'b1111;
      endcase
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ip_dst_nxt  = r_ip_dst;
      w_ports_nxt   = r_ports;
      w_len_nxt     = r_len;
      w_wcnt_nxt    = r_wcnt;
      w_to_cnt_nxt  = r_to_cnt;
      w_hdr_ack_nxt = r_hdr_ack;
      w_pay_got_nxt = r_pay_got;
      w_data_nxt    = r_tx_data;
      w_keep_nxt    = r_tx_keep;
      w_valid_nxt   = r_tx_valid;
      w_last_nxt    = r_tx_last;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_hdr_loaded) begin
               w_ip_dst_nxt  = in_reg1;
               w_ports_nxt   = in_reg2;
               w_len_nxt     = in_reg4[15:0];
               w_hdr_ack_nxt = 1'b1;
               w_state_nxt   = S_HDR_ACK;
            end
         end
         S_HDR_ACK: begin
            if (w_hdr_clear) begin
               w_hdr_ack_nxt = 1'b0;
               if (r_len > c_MAX_LEN) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = S_ERR;
               end else begin
                  w_wcnt_nxt  = 14'd0;
                  w_data_nxt  = r_ports;
                  w_keep_nxt  = 4'b1111;
                  w_last_nxt  = 1'b0;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = S_HDR0;
               end
            end
         end
         S_HDR0: begin
            if (w_accept) begin
               w_data_nxt  = {r_len + 16'd8, 16'h0000};
               w_last_nxt  = (r_len == 16'd0);
               w_state_nxt = S_HDR1;
            end
         end
         S_HDR1: begin
            if (w_accept) begin
               w_valid_nxt = 1'b0;
               w_data_nxt  = 32'd0;
               w_keep_nxt  = 4'd0;
               w_last_nxt  = 1'b0;
               if (r_len == 16'd0) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_to_cnt_nxt = 24'd0;
                  w_state_nxt  = S_PAY_WAIT;
               end
            end
         end
         S_PAY_WAIT: begin
            if (slv_reg3_loaded) begin
               w_data_nxt    = in_reg3;
               w_valid_nxt   = 1'b1;
               w_pay_got_nxt = 1'b1;
               w_last_nxt    = w_last_word;
               w_keep_nxt    = w_last_word ? w_last_keep : 4'b1111;
               w_state_nxt   = S_PAY_SEND;
            end else if (w_to_hit) begin
               // Empty last beat closes the frame downstream.
               w_data_nxt  = 32'd0;
               w_keep_nxt  = 4'd0;
               w_last_nxt  = 1'b1;
               w_valid_nxt = 1'b1;
               w_state_nxt = S_TO_SEND;
            end else begin
               w_to_cnt_nxt = r_to_cnt + 24'd1;
            end
         end
         S_PAY_SEND: begin
            // Stream accept and register-file release complete independently.
            if (w_accept) begin
               w_valid_nxt = 1'b0;
               w_data_nxt  = 32'd0;
               w_keep_nxt  = 4'd0;
               w_last_nxt  = 1'b0;
            end
            if (!slv_reg3_loaded) begin
               w_pay_got_nxt = 1'b0;
            end
            if (!w_valid_nxt && !w_pay_got_nxt) begin
               if (w_last_word) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_wcnt_nxt   = r_wcnt + 14'd1;
                  w_to_cnt_nxt = 24'd0;
                  w_state_nxt  = S_PAY_WAIT;
               end
            end
         end
         S_TO_SEND: begin
            if (w_accept) begin
               w_valid_nxt = 1'b0;
               w_last_nxt  = 1'b0;
               w_err_nxt   = 1'b1;
               w_state_nxt = S_ERR;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         S_ERR:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ip_dst   <= 32'd0;
         r_ports    <= 32'd0;
         r_len      <= 16'd0;
         r_wcnt     <= 14'd0;
         r_to_cnt   <= 24'd0;
         r_hdr_ack  <= 1'b0;
         r_pay_got  <= 1'b0;
         r_tx_data  <= 32'd0;
         r_tx_keep  <= 4'd0;
         r_tx_valid <= 1'b0;
         r_tx_last  <= 1'b0;
         r_busy     <= 1'b0;
         r_tx_done  <= 1'b0;
         r_tx_err   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ip_dst   <= w_ip_dst_nxt;
         r_ports    <= w_ports_nxt;
         r_len      <= w_len_nxt;
         r_wcnt     <= w_wcnt_nxt;
         r_to_cnt   <= w_to_cnt_nxt;
         r_hdr_ack  <= w_hdr_ack_nxt;
         r_pay_got  <= w_pay_got_nxt;
         r_tx_data  <= w_data_nxt;
         r_tx_keep  <= w_keep_nxt;
         r_tx_valid <= w_valid_nxt;
         r_tx_last  <= w_last_nxt;
         r_busy     <= w_busy_nxt;
         r_tx_done  <= w_done_nxt;
         r_tx_err   <= w_err_nxt;
      end
   end

   assign dip_got            = r_hdr_ack;
   assign src_dest_prt_got   = r_hdr_ack;
   assign payload_length_got = r_hdr_ack;
   assign payload_got        = r_pay_got;
   assign ip_dst             = r_ip_dst;
   assign tx_data            = r_tx_data;
   assign tx_keep            = r_tx_keep;
   assign tx_valid           = r_tx_valid;
   assign tx_last            = r_tx_last;
   assign busy               = r_busy;
   assign tx_done            = r_tx_done;
   assign tx_err             = r_tx_err;

endmodule
`default_nettype wire
